// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan-code consumer: pops bytes from the receiver FIFO and decodes make/break/extended
// sequences into key events, tracking the held key, typematic repeats and statistics.
module ps2_scan_sequencer #(
    parameter int unsigned TIMEOUT_CYC   = 2000000,
    parameter bit          REPORT_REPEAT = 1'b0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    input  logic             clr_stat,
    output logic             nextdata_n,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic             held_valid,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err,
    output logic             ovf_sticky
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StPop, StWait} state_e;

    state_e           state_q, state_d;
    logic             evt_valid_q, evt_valid_d;
    logic [7:0]       evt_code_q, evt_code_d;
    logic             evt_ext_q, evt_ext_d;
    logic             evt_break_q, evt_break_d;
    logic             evt_repeat_q, evt_repeat_d;
    logic             held_valid_q, held_valid_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             capture;
    logic             press_inc;

    always_comb begin
        state_d      = state_q;
        evt_valid_d  = 1'b0;
        err_d        = 1'b0;
        evt_code_d   = evt_code_q;
        evt_ext_d    = evt_ext_q;
        evt_break_d  = evt_break_q;
        evt_repeat_d = evt_repeat_q;
        held_valid_d = held_valid_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        tmo_cnt_d    = tmo_cnt_q;
        press_inc    = 1'b0;
        capture      = (state_q == StIdle) && kb_ready;

        case (state_q)
            StIdle:  if (kb_ready) state_d = StPop;
            StPop:   state_d = StWait;
            default: state_d = StIdle;
        endcase

        if (capture) begin
            tmo_cnt_d = '0;
            case (kb_data)
                8'hE0: ext_pend_d = 1'b1;
                8'hF0: brk_pend_d = 1'b1;
                8'hE1: ;
                8'h00, 8'hFF: begin
                    err_d      = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
                default: begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (brk_pend_q) begin
                        evt_valid_d  = 1'b1;
                        evt_code_d   = kb_data;
                        evt_ext_d    = ext_pend_q;
                        evt_break_d  = 1'b1;
                        evt_repeat_d = 1'b0;
                        if (held_ext_q == ext_pend_q && held_code_q == kb_data) begin
                            held_valid_d = 1'b0;
                        end
                    end else if (held_valid_q && held_ext_q == ext_pend_q &&
                                 held_code_q == kb_data) begin
                        // Typematic repeat of the held key: never counted as a press
                        if (REPORT_REPEAT) begin
                            evt_valid_d  = 1'b1;
                            evt_code_d   = kb_data;
                            evt_ext_d    = ext_pend_q;
                            evt_break_d  = 1'b0;
                            evt_repeat_d = 1'b1;
                        end
                    end else begin
                        evt_valid_d  = 1'b1;
                        evt_code_d   = kb_data;
                        evt_ext_d    = ext_pend_q;
                        evt_break_d  = 1'b0;
                        evt_repeat_d = 1'b0;
                        held_valid_d = 1'b1;
                        held_code_d  = kb_data;
                        held_ext_d   = ext_pend_q;
                        press_inc    = 1'b1;
                    end
                end
            endcase
        end else if (ext_pend_q || brk_pend_q) begin
            // Stale prefix is dropped silently once the idle window expires
            if (tmo_cnt_q == TmoLast) begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                tmo_cnt_d  = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end

        if (clr_stat) begin
            press_cnt_d = '0;
        end else begin
            press_cnt_d = press_cnt_q + CNT_W'(press_inc);
        end

        if (kb_overflow) begin
            ovf_d = 1'b1;
        end else if (clr_stat) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= '0;
            evt_ext_q    <= 1'b0;
            evt_break_q  <= 1'b0;
            evt_repeat_q <= 1'b0;
            held_valid_q <= 1'b0;
            held_code_q  <= '0;
            held_ext_q   <= 1'b0;
            press_cnt_q  <= '0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            evt_valid_q  <= evt_valid_d;
            evt_code_q   <= evt_code_d;
            evt_ext_q    <= evt_ext_d;
            evt_break_q  <= evt_break_d;
            evt_repeat_q <= evt_repeat_d;
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
            press_cnt_q  <= press_cnt_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign nextdata_n = (state_q != StPop);
    assign evt_valid  = evt_valid_q;
    assign evt_code   = evt_code_q;
    assign evt_ext    = evt_ext_q;
    assign evt_break  = evt_break_q;
    assign evt_repeat = evt_repeat_q;
    assign held_valid = held_valid_q;
    assign held_code  = held_code_q;
    assign held_ext   = held_ext_q;
    assign press_cnt  = press_cnt_q;
    assign err        = err_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: two instances (repeats suppressed / reported)
// share one stimulus stream.
module tb_ps2_scan_sequencer;

    localparam int unsigned TMO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;
    logic       clr_stat = 1'b0;

    logic       nextdata_n0, evt_valid0, evt_ext0, evt_break0, evt_repeat0;
    logic       held_valid0, held_ext0, err0, ovf0;
    logic [7:0] evt_code0, held_code0, press_cnt0;
    logic       nextdata_n1, evt_valid1, evt_ext1, evt_break1, evt_repeat1;
    logic       held_valid1, held_ext1, err1, ovf1;
    logic [7:0] evt_code1, held_code1, press_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int ev0_cnt  = 0;
    int ev1_cnt  = 0;
    int rep1_cnt = 0;
    int err_cnt  = 0;
    int nd_cnt   = 0;

    always #5 clk = ~clk;

    ps2_scan_sequencer #(.TIMEOUT_CYC(TMO), .REPORT_REPEAT(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow), .clr_stat(clr_stat), .nextdata_n(nextdata_n0),
        .evt_valid(evt_valid0), .evt_code(evt_code0), .evt_ext(evt_ext0),
        .evt_break(evt_break0), .evt_repeat(evt_repeat0), .held_valid(held_valid0),
        .held_code(held_code0), .held_ext(held_ext0), .press_cnt(press_cnt0),
        .err(err0), .ovf_sticky(ovf0)
    );

    ps2_scan_sequencer #(.TIMEOUT_CYC(TMO), .REPORT_REPEAT(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow), .clr_stat(clr_stat), .nextdata_n(nextdata_n1),
        .evt_valid(evt_valid1), .evt_code(evt_code1), .evt_ext(evt_ext1),
        .evt_break(evt_break1), .evt_repeat(evt_repeat1), .held_valid(held_valid1),
        .held_code(held_code1), .held_ext(held_ext1), .press_cnt(press_cnt1),
        .err(err1), .ovf_sticky(ovf1)
    );

    // Pulse counters sample pre-edge values, so tasks reading them at negedge never race
    always @(posedge clk) begin
        if (!rst) begin
            if (evt_valid0) ev0_cnt++;
            if (evt_valid1) ev1_cnt++;
            if (evt_valid1 && evt_repeat1) rep1_cnt++;
            if (err0) err_cnt++;
            if (!nextdata_n0) nd_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; kb_ready = 1'b0; clr_stat = 1'b0; kb_overflow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One byte through IDLE -> POP -> WAIT; returns at the WAIT-cycle negedge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        kb_data = b; kb_ready = 1'b1;
        @(negedge clk);
        kb_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        if (nextdata_n0 !== 1'b1) begin
            $display("FAIL reset_nextdata_n: got %b expected 1", nextdata_n0); n_fail++;
        end
        n_checks++;
        if ({evt_valid0, evt_code0, evt_ext0, evt_break0, evt_repeat0} !== 12'h000) begin
            $display("FAIL reset_evt: got %b%h%b%b%b expected all zero", evt_valid0,
                     evt_code0, evt_ext0, evt_break0, evt_repeat0); n_fail++;
        end
        n_checks++;
        if ({held_valid0, held_code0, held_ext0, err0, ovf0, press_cnt0} !== 20'h0) begin
            $display("FAIL reset_state: held %b/%h/%b err %b ovf %b cnt %0d expected zeros",
                     held_valid0, held_code0, held_ext0, err0, ovf0, press_cnt0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_single_make();
        int e0, n0;
        e0 = ev0_cnt; n0 = nd_cnt;
        @(negedge clk);
        kb_data = 8'h15; kb_ready = 1'b1;
        @(negedge clk);
        if ({nextdata_n0, evt_valid0, evt_code0, evt_ext0, evt_break0} !== {2'b01, 8'h15, 2'b00})
        begin
            $display("FAIL make_pop: nd %b valid %b code %h ext %b brk %b expected 0 1 15 0 0",
                     nextdata_n0, evt_valid0, evt_code0, evt_ext0, evt_break0); n_fail++;
        end
        n_checks++;
        @(negedge clk);
        if ({nextdata_n0, evt_valid0} !== 2'b10) begin
            $display("FAIL make_wait: nd %b valid %b expected 1 0", nextdata_n0, evt_valid0);
            n_fail++;
        end
        n_checks++;
        @(negedge clk);
        kb_ready = 1'b0;
        if ({nextdata_n0, evt_valid0} !== 2'b10) begin
            $display("FAIL make_idle: nd %b valid %b expected 1 0", nextdata_n0, evt_valid0);
            n_fail++;
        end
        n_checks++;
        @(negedge clk);
        if (ev0_cnt - e0 !== 1 || nd_cnt - n0 !== 1) begin
            $display("FAIL make_counts: events %0d pops %0d expected 1 1",
                     ev0_cnt - e0, nd_cnt - n0); n_fail++;
        end
        n_checks++;
        if ({press_cnt0, held_valid0, held_code0, held_ext0} !== {8'd1, 1'b1, 8'h15, 1'b0}) begin
            $display("FAIL make_held: cnt %0d held %b/%h/%b expected 1 1/15/0",
                     press_cnt0, held_valid0, held_code0, held_ext0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_repeat();
        int e0, e1, r1;
        do_reset();
        e0 = ev0_cnt; e1 = ev1_cnt; r1 = rep1_cnt;
        send_byte(8'h15); send_byte(8'h15); send_byte(8'h15);
        send_byte(8'hF0); send_byte(8'h15);
        if (ev0_cnt - e0 !== 2) begin
            $display("FAIL repeat_off_events: got %0d expected 2", ev0_cnt - e0); n_fail++;
        end
        n_checks++;
        if (ev1_cnt - e1 !== 4 || rep1_cnt - r1 !== 2) begin
            $display("FAIL repeat_on_events: got %0d/%0d repeats expected 4/2",
                     ev1_cnt - e1, rep1_cnt - r1); n_fail++;
        end
        n_checks++;
        if ({press_cnt0, press_cnt1, held_valid0, held_valid1} !== {8'd1, 8'd1, 2'b00}) begin
            $display("FAIL repeat_stats: cnt %0d/%0d held %b/%b expected 1/1 0/0",
                     press_cnt0, press_cnt1, held_valid0, held_valid1); n_fail++;
        end
        n_checks++;
        if ({evt_break0, evt_repeat0, evt_code0} !== {2'b10, 8'h15}) begin
            $display("FAIL repeat_last_evt: brk %b rep %b code %h expected 1 0 15",
                     evt_break0, evt_repeat0, evt_code0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0); send_byte(8'h75);
        if ({evt_code0, evt_ext0, evt_break0, held_ext0, press_cnt0} !==
            {8'h75, 3'b101, 8'd1}) begin
            $display("FAIL ext_make: code %h ext %b brk %b held_ext %b cnt %0d expected 75 1 0 1 1",
                     evt_code0, evt_ext0, evt_break0, held_ext0, press_cnt0); n_fail++;
        end
        n_checks++;
        send_byte(8'h75);
        if ({evt_ext0, held_ext0, held_code0, press_cnt0} !== {2'b00, 8'h75, 8'd2}) begin
            $display("FAIL ext_plain_new: ext %b held_ext %b held %h cnt %0d expected 0 0 75 2",
                     evt_ext0, held_ext0, held_code0, press_cnt0); n_fail++;
        end
        n_checks++;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        if ({evt_code0, evt_ext0, evt_break0, held_valid0} !== {8'h75, 3'b111}) begin
            $display("FAIL ext_break: code %h ext %b brk %b held %b expected 75 1 1 1",
                     evt_code0, evt_ext0, evt_break0, held_valid0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hF0);
        repeat (TMO + 5) @(negedge clk);
        send_byte(8'h23);
        if ({evt_code0, evt_break0, press_cnt0, held_valid0} !== {8'h23, 1'b0, 8'd1, 1'b1}) begin
            $display("FAIL timeout_make: code %h brk %b cnt %0d held %b expected 23 0 1 1",
                     evt_code0, evt_break0, press_cnt0, held_valid0); n_fail++;
        end
        n_checks++;
        send_byte(8'hF0);
        repeat (5) @(negedge clk);
        send_byte(8'h23);
        if ({evt_code0, evt_break0, press_cnt0, held_valid0} !== {8'h23, 1'b1, 8'd1, 1'b0}) begin
            $display("FAIL short_gap_break: code %h brk %b cnt %0d held %b expected 23 1 1 0",
                     evt_code0, evt_break0, press_cnt0, held_valid0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_err_stats();
        int e0, r0;
        do_reset();
        e0 = ev0_cnt; r0 = err_cnt;
        send_byte(8'h00);
        if (err_cnt - r0 !== 1 || ev0_cnt - e0 !== 0) begin
            $display("FAIL err_byte: errs %0d events %0d expected 1 0",
                     err_cnt - r0, ev0_cnt - e0); n_fail++;
        end
        n_checks++;
        send_byte(8'hF0); send_byte(8'hFF); send_byte(8'h15);
        if ({evt_break0, held_valid0, press_cnt0, err_cnt - r0} !== {2'b01, 8'd1, 32'd2}) begin
            $display("FAIL err_clears_prefix: brk %b held %b cnt %0d errs %0d expected 0 1 1 2",
                     evt_break0, held_valid0, press_cnt0, err_cnt - r0); n_fail++;
        end
        n_checks++;
        @(negedge clk); kb_overflow = 1'b1;
        @(negedge clk); kb_overflow = 1'b0;
        if (ovf0 !== 1'b1) begin
            $display("FAIL ovf_set: got %b expected 1", ovf0); n_fail++;
        end
        n_checks++;
        @(negedge clk);
        kb_data = 8'h2B; kb_ready = 1'b1; clr_stat = 1'b1;
        @(negedge clk);
        kb_ready = 1'b0; clr_stat = 1'b0;
        @(negedge clk);
        if ({press_cnt0, ovf0, held_code0, evt_code0} !== {8'd0, 1'b0, 8'h2B, 8'h2B}) begin
            $display("FAIL clr_vs_press: cnt %0d ovf %b held %h code %h expected 0 0 2b 2b",
                     press_cnt0, ovf0, held_code0, evt_code0); n_fail++;
        end
        n_checks++;
        @(negedge clk); kb_overflow = 1'b1; clr_stat = 1'b1;
        @(negedge clk); kb_overflow = 1'b0; clr_stat = 1'b0;
        if (ovf0 !== 1'b1) begin
            $display("FAIL ovf_vs_clr: got %b expected 1", ovf0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'h15);
        @(negedge clk);
        kb_data = 8'hF0; kb_ready = 1'b1;
        @(negedge clk);
        kb_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if ({nextdata_n0, held_valid0, press_cnt0, evt_valid0} !== {2'b10, 8'd0, 1'b0}) begin
            $display("FAIL reset_mid: nd %b held %b cnt %0d valid %b expected 1 0 0 0",
                     nextdata_n0, held_valid0, press_cnt0, evt_valid0); n_fail++;
        end
        n_checks++;
        send_byte(8'h15);
        if ({evt_code0, evt_break0, held_valid0, press_cnt0} !== {8'h15, 2'b01, 8'd1}) begin
            $display("FAIL reset_mid_make: code %h brk %b held %b cnt %0d expected 15 0 1 1",
                     evt_code0, evt_break0, held_valid0, press_cnt0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) send_byte((i % 2 == 0) ? 8'h15 : 8'h16);
        if (press_cnt0 !== 8'd0) begin
            $display("FAIL wrap_256: got %0d expected 0", press_cnt0); n_fail++;
        end
        n_checks++;
        send_byte(8'h1C);
        if (press_cnt0 !== 8'd1) begin
            $display("FAIL wrap_257: got %0d expected 1", press_cnt0); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_repeat();
        test_extended();
        test_timeout();
        test_err_stats();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
